fx3_gpif_responder: RTL and testbench

FX3_GPIF_RESPONDER -- requirements
Module: fx3_gpif_responder

---
 rtl/fx3_gpif_responder.sv | 202 ++++++++++++++++++++
 tb/tb_fx3_gpif_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_gpif_responder.sv
// FX3 GPIF-II slave-FIFO responder: master-facing bus FSM between two 2^FIFO_DEPTH x 33 socket FIFOs.
// Socket 0 (TXF) carries host-source words to the master; socket 1 (RXF) carries master words to the host sink.
module fx3_gpif_responder #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cs_n,
   input  logic        i_oe_n,
   input  logic        i_we_n,
   input  logic        i_re_n,
   input  logic        i_pkt_end_n,
   input  logic [1:0]  i_socket_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   output logic        o_data_oe,
   output logic        o_in_rdy,
   output logic        o_out_rdy,
   input  logic        i_usb3_data_size_sel,
   input  logic [31:0] i_src_data,
   input  logic        i_src_valid,
   output logic        o_src_ready,
   output logic [31:0] o_snk_data,
   output logic        o_snk_valid,
   output logic        o_snk_last,
   input  logic        i_snk_ready,
   output logic        o_overflow,
   output logic        o_underflow
);

   localparam int unsigned DEPTH = 1 << FIFO_DEPTH;
   localparam int unsigned CW    = FIFO_DEPTH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [7:0]    LAT_LOAD = 8'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_RLAT,
      S_READ,
      S_WRITE,
      S_TURN
   } state_t;

   state_t state_q, state_d;
   logic [1:0]            sock_q, sock_d;
   logic [7:0]            lat_q, lat_d;
   logic [8:0]            wcnt_q, wcnt_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  src_rdy_q, src_rdy_d;
   logic                  in_rdy_q, in_rdy_d;
   logic                  out_rdy_q, out_rdy_d;
   logic [FIFO_DEPTH-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [FIFO_DEPTH-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

   logic [32:0] tx_mem [DEPTH];
   logic [32:0] rx_mem [DEPTH];

   logic        tx_empty, rx_empty, rx_full;
   logic [32:0] tx_head, rx_head;
   logic        rd_active, wr_strobe;
   logic        tx_push, tx_pop, rx_push, rx_pop, rx_last;
   logic [8:0]  pkt, wcnt_inc;
   logic        flag_state;

   assign tx_empty = (tx_cnt_q == '0);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);
   // TXF bit 32 marks a stored word, so an empty head reads back with bit 32 clear.
   assign tx_head  = tx_empty ? '0 : tx_mem[tx_rd_q];
   assign rx_head  = rx_empty ? '0 : rx_mem[rx_rd_q];
   assign pkt      = i_usb3_data_size_sel ? 9'd256 : 9'd128;
   assign wcnt_inc = (wcnt_q == 9'h1FF) ? wcnt_q : wcnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      sock_d    = sock_q;
      lat_d     = lat_q;
      wcnt_d    = wcnt_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      rd_active = 1'b0;
      wr_strobe = 1'b0;

      case (state_q)
         S_IDLE: begin
            wcnt_d = '0;
            if (!i_cs_n) state_d = S_ADDR;
         end
         S_ADDR: begin
            sock_d = i_socket_addr;
            if (i_cs_n) begin
               state_d = S_IDLE;
            end else if (i_socket_addr == 2'd0 && !i_oe_n && !i_re_n) begin
               state_d = S_RLAT;
               lat_d   = LAT_LOAD;
            end else if (i_socket_addr == 2'd1 && !i_we_n) begin
               state_d   = S_WRITE;
               wr_strobe = 1'b1;
            end
         end
         S_RLAT: begin
            if (lat_q == '0) state_d = S_READ;
            else             lat_d   = lat_q - 1'b1;
         end
         S_READ: begin
            if (i_re_n || i_cs_n) state_d = S_TURN;
            else                  rd_active = (sock_q == 2'd0);
         end
         S_WRITE: begin
            if (i_we_n || i_cs_n) state_d = S_TURN;
            else                  wr_strobe = (sock_q == 2'd1);
         end
         S_TURN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      tx_pop  = rd_active && !tx_empty;
      tx_push = i_src_valid && src_rdy_q;
      rx_pop  = !rx_empty && i_snk_ready;
      rx_push = wr_strobe && !rx_full;
      rx_last = !i_pkt_end_n || (wcnt_inc == pkt);
      if (rd_active && tx_empty) udf_d = 1'b1;
      if (wr_strobe) begin
         wcnt_d = wcnt_inc;
         if (rx_full) ovf_d = 1'b1;
      end

      tx_wr_d  = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
      tx_rd_d  = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
      rx_wr_d  = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
      rx_rd_d  = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
      if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
      if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;

      // Flags are registered from next-state values so they track the live state and counts.
      flag_state = (state_d == S_IDLE) || (state_d == S_TURN);
      src_rdy_d  = (tx_cnt_d != FULL_CNT);
      in_rdy_d   = flag_state && (32'(tx_cnt_d) >= 32'(pkt));
      out_rdy_d  = flag_state && ((32'(DEPTH) - 32'(rx_cnt_d)) >= 32'(pkt));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sock_q    <= '0;
         lat_q     <= '0;
         wcnt_q    <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         src_rdy_q <= 1'b0;
         in_rdy_q  <= 1'b0;
         out_rdy_q <= 1'b0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         sock_q    <= sock_d;
         lat_q     <= lat_d;
         wcnt_q    <= wcnt_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         src_rdy_q <= src_rdy_d;
         in_rdy_q  <= in_rdy_d;
         out_rdy_q <= out_rdy_d;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q] <= {1'b1, i_src_data};
      if (rx_push) rx_mem[rx_wr_q] <= {rx_last, i_data};
   end

   assign o_data_oe   = rd_active;
   assign o_data      = rd_active ? (tx_head[32] ? tx_head[31:0] : 32'hDEADBEEF) : '0;
   assign o_in_rdy    = in_rdy_q;
   assign o_out_rdy   = out_rdy_q;
   assign o_src_ready = src_rdy_q;
   assign o_snk_valid = !rx_empty;
   assign o_snk_data  = rx_head[31:0];
   assign o_snk_last  = rx_head[32];
   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;

endmodule

// File: tb/tb_fx3_gpif_responder.sv
// Directed bench for fx3_gpif_responder: master read/write bursts, packet flags, under/overflow, reset.
module tb_fx3_gpif_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n, oe_n, we_n, re_n, pkt_end_n;
   logic [1:0]  sock;
   logic [31:0] din, dout;
   logic        doe, in_rdy, out_rdy, sel;
   logic [31:0] src_data;
   logic        src_valid, src_ready;
   logic [31:0] snk_data;
   logic        snk_valid, snk_last, snk_ready;
   logic        ovf, udf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fx3_gpif_responder #(.FIFO_DEPTH(8), .READ_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cs_n(cs_n), .i_oe_n(oe_n), .i_we_n(we_n), .i_re_n(re_n),
      .i_pkt_end_n(pkt_end_n), .i_socket_addr(sock),
      .i_data(din), .o_data(dout), .o_data_oe(doe),
      .o_in_rdy(in_rdy), .o_out_rdy(out_rdy),
      .i_usb3_data_size_sel(sel),
      .i_src_data(src_data), .i_src_valid(src_valid), .o_src_ready(src_ready),
      .o_snk_data(snk_data), .o_snk_valid(snk_valid), .o_snk_last(snk_last),
      .i_snk_ready(snk_ready),
      .o_overflow(ovf), .o_underflow(udf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; re_n = 1'b1; pkt_end_n = 1'b1;
   endtask

   task automatic push_src(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         src_valid = 1'b1;
         src_data  = base + 32'(i);
         tick();
      end
      src_valid = 1'b0;
   endtask

   // Starts a socket-0 read; returns once the first READ cycle is live.
   task automatic start_read();
      cs_n = 1'b0; sock = 2'd0; oe_n = 1'b0; re_n = 1'b0;
      tick(); tick(); tick(); tick();
   endtask

   task automatic end_burst();
      bus_idle();
      tick(); tick();
   endtask

   // Socket-1 write of n words base+1..base+n; pkt_end_n low on word end_at (0 = never).
   task automatic write_burst(input int n, input logic [31:0] base, input int end_at);
      cs_n = 1'b0; sock = 2'd1; we_n = 1'b0;
      tick();
      for (int k = 1; k <= n; k++) begin
         din       = base + 32'(k);
         pkt_end_n = (k == end_at) ? 1'b0 : 1'b1;
         tick();
      end
      end_burst();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_idle();
      sock = 2'd0; din = '0; sel = 1'b0;
      src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      total++; if (doe !== 1'b0)       begin bad++; $display("FAIL reset_oe got=%b exp=0", doe); end
      total++; if (dout !== 32'h0)     begin bad++; $display("FAIL reset_data got=%h exp=0", dout); end
      total++; if ({in_rdy, out_rdy} !== 2'b00) begin bad++; $display("FAIL reset_rdy got=%b exp=00", {in_rdy, out_rdy}); end
      total++; if ({src_ready, snk_valid, snk_last} !== 3'b000) begin bad++; $display("FAIL reset_hs got=%b exp=000", {src_ready, snk_valid, snk_last}); end
      total++; if ({ovf, udf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {ovf, udf}); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL src_ready_pre got=%b exp=0", src_ready); end
      tick();
      total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL src_ready_rise got=%b exp=1", src_ready); end
      total++; if ({in_rdy, out_rdy} !== 2'b01) begin bad++; $display("FAIL idle_rdy got=%b exp=01", {in_rdy, out_rdy}); end
   endtask

   task automatic test_read_burst();
      sel = 1'b0;
      push_src(127, 32'h0);
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL in_rdy_127 got=%b exp=0", in_rdy); end
      push_src(1, 32'd127);
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL in_rdy_128 got=%b exp=1", in_rdy); end
      cs_n = 1'b0; sock = 2'd0; oe_n = 1'b0; re_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL in_rdy_busy got=%b exp=0", in_rdy); end
      total++; if (doe !== 1'b0) begin bad++; $display("FAIL read_lat1 got=%b exp=0", doe); end
      tick(); tick();
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         total++; if (doe !== 1'b1 || dout !== 32'(i)) begin bad++; $display("FAIL read_word%0d got=%b/%h exp=1/%h", i, doe, dout, 32'(i)); end
         tick();
      end
      re_n = 1'b1;
      @(negedge clk);
      total++; if (doe !== 1'b0) begin bad++; $display("FAIL read_release got=%b exp=0", doe); end
      end_burst();
      total++; if (udf !== 1'b0) begin bad++; $display("FAIL read_no_udf got=%b exp=0", udf); end
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL in_rdy_drained got=%b exp=0", in_rdy); end
   endtask

   task automatic test_write_pkt();
      sel = 1'b0;
      cs_n = 1'b0; sock = 2'd1; we_n = 1'b0;
      tick();
      for (int k = 1; k <= 5; k++) begin
         din       = 32'hA000_0000 + 32'(k);
         pkt_end_n = (k == 5) ? 1'b0 : 1'b1;
         if (k == 3) begin
            @(negedge clk);
            total++; if (out_rdy !== 1'b0) begin bad++; $display("FAIL out_rdy_busy got=%b exp=0", out_rdy); end
         end
         tick();
      end
      end_burst();
      total++; if (out_rdy !== 1'b1) begin bad++; $display("FAIL out_rdy_back got=%b exp=1", out_rdy); end
      snk_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if ({snk_valid, snk_last, snk_data} !== {1'b1, (k == 5), 32'hA000_0000 + 32'(k)}) begin
            bad++; $display("FAIL snk_word%0d got=%b/%b/%h exp=1/%b/%h", k, snk_valid, snk_last, snk_data, (k == 5), 32'hA000_0000 + 32'(k));
         end
         tick();
      end
      total++; if (snk_valid !== 1'b0) begin bad++; $display("FAIL snk_empty5 got=%b exp=0", snk_valid); end
      snk_ready = 1'b0;
   endtask

   task automatic test_full_packet();
      sel = 1'b1;
      write_burst(256, 32'h1000_0000, 0);
      total++; if (out_rdy !== 1'b0) begin bad++; $display("FAIL out_rdy_full got=%b exp=0", out_rdy); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_256 got=%b exp=0", ovf); end
      snk_ready = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         total++;
         if ({snk_valid, snk_last, snk_data} !== {1'b1, (k == 256), 32'h1000_0000 + 32'(k)}) begin
            bad++; $display("FAIL full_word%0d got=%b/%b/%h exp=1/%b/%h", k, snk_valid, snk_last, snk_data, (k == 256), 32'h1000_0000 + 32'(k));
         end
         if (k == 2) begin
            total++; if (out_rdy !== 1'b0) begin bad++; $display("FAIL out_rdy_255 got=%b exp=0", out_rdy); end
         end
         tick();
      end
      snk_ready = 1'b0;
      total++; if ({snk_valid, out_rdy} !== 2'b01) begin bad++; $display("FAIL full_drained got=%b exp=01", {snk_valid, out_rdy}); end
      sel = 1'b0;
   endtask

   task automatic test_addr_abort();
      cs_n = 1'b0; sock = 2'd1; we_n = 1'b1;
      tick();
      cs_n = 1'b1; we_n = 1'b0; din = 32'h0BAD_0BAD;
      tick(); tick();
      we_n = 1'b1;
      tick();
      total++; if (snk_valid !== 1'b0) begin bad++; $display("FAIL addr_abort got=%b exp=0", snk_valid); end
   endtask

   task automatic test_underflow();
      push_src(1, 32'h5555_0001);
      start_read();
      @(negedge clk);
      total++; if (dout !== 32'h5555_0001) begin bad++; $display("FAIL udf_word1 got=%h exp=55550001", dout); end
      tick();
      total++; if (udf !== 1'b0) begin bad++; $display("FAIL udf_early got=%b exp=0", udf); end
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL udf_word%0d got=%h exp=deadbeef", k, dout); end
         tick();
      end
      end_burst();
      total++; if (udf !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", udf); end
   endtask

   task automatic test_overflow();
      sel = 1'b0;
      cs_n = 1'b0; sock = 2'd1; we_n = 1'b0;
      tick();
      for (int k = 1; k <= 257; k++) begin
         din = 32'h2000_0000 + 32'(k);
         if (k == 257) begin
            total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
         end
         tick();
      end
      end_burst();
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
      snk_ready = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         total++;
         if ({snk_valid, snk_last, snk_data} !== {1'b1, (k == 128), 32'h2000_0000 + 32'(k)}) begin
            bad++; $display("FAIL ovf_word%0d got=%b/%b/%h exp=1/%b/%h", k, snk_valid, snk_last, snk_data, (k == 128), 32'h2000_0000 + 32'(k));
         end
         tick();
      end
      snk_ready = 1'b0;
      total++; if (snk_valid !== 1'b0) begin bad++; $display("FAIL ovf_256_only got=%b exp=0", snk_valid); end
   endtask

   task automatic test_reset_mid_read();
      push_src(4, 32'h7700_0000);
      start_read();
      @(negedge clk);
      total++; if (doe !== 1'b1) begin bad++; $display("FAIL mid_read_oe got=%b exp=1", doe); end
      #1 rst_n = 1'b0;
      #1;
      total++; if ({doe, dout} !== 33'h0) begin bad++; $display("FAIL rst_async_bus got=%b/%h exp=0/0", doe, dout); end
      total++; if ({ovf, udf, src_ready, snk_valid} !== 4'b0000) begin bad++; $display("FAIL rst_async_flags got=%b exp=0000", {ovf, udf, src_ready, snk_valid}); end
      bus_idle();
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst_tx_empty got=%b exp=0", in_rdy); end
      start_read();
      @(negedge clk);
      total++; if ({doe, dout} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL rst_read_empty got=%b/%h exp=1/deadbeef", doe, dout); end
      tick();
      end_burst();
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_pkt();
      test_full_packet();
      test_addr_abort();
      test_underflow();
      test_overflow();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
